// File: rtl/ic_emu_pkg.sv
// Shared encodings, config bundle and gate evaluation
// for the dual 4-input logic IC emulator.
package ic_emu_pkg;

    localparam logic [2:0] GATE_AND  = 3'b000;
    localparam logic [2:0] GATE_NAND = 3'b001;
    localparam logic [2:0] GATE_OR   = 3'b010;
    localparam logic [2:0] GATE_NOR  = 3'b011;
    localparam logic [2:0] GATE_XOR  = 3'b100;
    localparam logic [2:0] GATE_XNOR = 3'b101;

    localparam logic [1:0] FAULT_NONE = 2'b00;
    localparam logic [1:0] FAULT_SA0  = 2'b01;
    localparam logic [1:0] FAULT_SA1  = 2'b10;
    localparam logic [1:0] FAULT_INV  = 2'b11;

    typedef struct packed {
        logic [2:0] gate;
        logic [1:0] fault1;
        logic [1:0] fault2;
    } cfg_t;

    // Unused codes 11x fall through to AND.
    function automatic logic gate_eval(
        input logic [2:0] gate,
        input logic [3:0] vec
    );
        logic r;
        case (gate)
            GATE_NAND: r = ~&vec;
            GATE_OR:   r = |vec;
            GATE_NOR:  r = ~|vec;
            GATE_XOR:  r = ^vec;
            GATE_XNOR: r = ~^vec;
            default:   r = &vec;
        endcase
        return r;
    endfunction

    function automatic logic fault_apply(
        input logic [1:0] fault,
        input logic       x
    );
        logic r;
        case (fault)
            FAULT_SA0: r = 1'b0;
            FAULT_SA1: r = 1'b1;
            FAULT_INV: r = ~x;
            default:   r = x;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ic_emu_gate.sv
// One emulated gate: evaluation, fault injection, delay line,
// input-vector coverage and saturating output-toggle counter.
module ic_emu_gate
    import ic_emu_pkg::*;
#(
    parameter int DELAY_CYCLES = 4,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       gate,
    input  logic [1:0]       fault,
    input  logic [3:0]       vec,
    input  logic             cov_clear,
    output logic             op,
    output logic [15:0]      cov_mask,
    output logic             cov_full,
    output logic [CNT_W-1:0] toggles
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic                    stage_in;
    logic                    op_nxt;
    logic [DELAY_CYCLES-1:0] line;

    assign stage_in = fault_apply(fault, gate_eval(gate, vec));
    assign op       = line[DELAY_CYCLES-1];

    // line[0] holds the newest sample; op is the oldest stage.
    generate
        if (DELAY_CYCLES == 1) begin : g_d1
            assign op_nxt = stage_in;

            always_ff @(posedge clk) begin
                if (reset) begin
                    line <= '0;
                end else begin
                    line <= stage_in;
                end
            end
        end else begin : g_dn
            assign op_nxt = line[DELAY_CYCLES-2];

            always_ff @(posedge clk) begin
                if (reset) begin
                    line <= '0;
                end else begin
                    line <= {line[DELAY_CYCLES-2:0], stage_in};
                end
            end
        end
    endgenerate

    // Clear wins over the vector sampled in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || cov_clear) begin
            cov_mask <= '0;
            cov_full <= 1'b0;
        end else begin
            cov_mask <= cov_mask | (16'd1 << vec);
            cov_full <= &cov_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || cov_clear) begin
            toggles <= '0;
        end else if (op_nxt != op && toggles != CNT_MAX) begin
            toggles <= toggles + CNT_ONE;
        end
    end

endmodule

// File: rtl/ic_dut_emulator.sv
// Dual same-type 4-input logic IC emulator: shared gate function,
// per-gate fault modes, config registers and pin mapping.
module ic_dut_emulator
    import ic_emu_pkg::*;
#(
    parameter int DELAY_CYCLES = 4,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             A1,
    input  logic             B1,
    input  logic             C1,
    input  logic             D1,
    input  logic             A2,
    input  logic             B2,
    input  logic             C2,
    input  logic             D2,
    output logic             op1,
    output logic             op2,
    input  logic             cfg_load,
    input  logic [2:0]       cfg_gate,
    input  logic [1:0]       cfg_fault1,
    input  logic [1:0]       cfg_fault2,
    input  logic             cov_clear,
    output logic [15:0]      cov_mask1,
    output logic [15:0]      cov_mask2,
    output logic             cov_full1,
    output logic             cov_full2,
    output logic [CNT_W-1:0] toggles1,
    output logic [CNT_W-1:0] toggles2
);

    cfg_t cfg_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_q <= '{GATE_AND, FAULT_NONE, FAULT_NONE};
        end else if (cfg_load) begin
            cfg_q <= '{cfg_gate, cfg_fault1, cfg_fault2};
        end
    end

    ic_emu_gate #(
        .DELAY_CYCLES(DELAY_CYCLES),
        .CNT_W       (CNT_W)
    ) u_gate1 (
        .clk      (clk),
        .reset    (reset),
        .gate     (cfg_q.gate),
        .fault    (cfg_q.fault1),
        .vec      ({D1, C1, B1, A1}),
        .cov_clear(cov_clear),
        .op       (op1),
        .cov_mask (cov_mask1),
        .cov_full (cov_full1),
        .toggles  (toggles1)
    );

    ic_emu_gate #(
        .DELAY_CYCLES(DELAY_CYCLES),
        .CNT_W       (CNT_W)
    ) u_gate2 (
        .clk      (clk),
        .reset    (reset),
        .gate     (cfg_q.gate),
        .fault    (cfg_q.fault2),
        .vec      ({D2, C2, B2, A2}),
        .cov_clear(cov_clear),
        .op       (op2),
        .cov_mask (cov_mask2),
        .cov_full (cov_full2),
        .toggles  (toggles2)
    );

endmodule

// File: tb/tb_ic_dut_emulator.sv
// Bench for ic_dut_emulator: vector table, corner sequences and
// a randomized run against a history-based reference model.
module tb_ic_dut_emulator;

    localparam int D    = 4;
    localparam int MAXE = 8192;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       reset      = 1'b1;
    logic [3:0] v1         = '0;
    logic [3:0] v2         = '0;
    logic       cfg_load   = 1'b0;
    logic [2:0] cfg_gate   = '0;
    logic [1:0] cfg_fault1 = '0;
    logic [1:0] cfg_fault2 = '0;
    logic       cov_clear  = 1'b0;

    logic        op1, op2, cov_full1, cov_full2;
    logic [15:0] cov_mask1, cov_mask2;
    logic [7:0]  toggles1, toggles2;

    ic_dut_emulator #(
        .DELAY_CYCLES(D),
        .CNT_W       (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .A1        (v1[0]),
        .B1        (v1[1]),
        .C1        (v1[2]),
        .D1        (v1[3]),
        .A2        (v2[0]),
        .B2        (v2[1]),
        .C2        (v2[2]),
        .D2        (v2[3]),
        .op1       (op1),
        .op2       (op2),
        .cfg_load  (cfg_load),
        .cfg_gate  (cfg_gate),
        .cfg_fault1(cfg_fault1),
        .cfg_fault2(cfg_fault2),
        .cov_clear (cov_clear),
        .cov_mask1 (cov_mask1),
        .cov_mask2 (cov_mask2),
        .cov_full1 (cov_full1),
        .cov_full2 (cov_full2),
        .toggles1  (toggles1),
        .toggles2  (toggles2)
    );

    typedef struct {
        logic [2:0] gate;
        logic [1:0] f1;
        logic [1:0] f2;
        logic [3:0] v1;
        logic [3:0] v2;
        logic       e1;
        logic       e2;
    } vec_t;

    vec_t tbl [12];

    int n_chk    = 0;
    int n_fail   = 0;
    int edge_n   = 0;
    int rst_edge = 0;

    // Model: value produced at each edge, read back D-1 edges later.
    bit hist [2][MAXE];
    int m_gate = 0;
    int m_f    [2];
    int m_mask [2];
    int m_tog  [2];
    bit m_full [2];
    bit m_op   [2];

    function automatic bit ideal(int gate, logic [3:0] v);
        int ones;
        ones = $countones(v);
        case (gate)
            1:       return ones != 4;
            2:       return ones != 0;
            3:       return ones == 0;
            4:       return (ones % 2) == 1;
            5:       return (ones % 2) == 0;
            default: return ones == 4;
        endcase
    endfunction

    function automatic bit faulted(int f, bit x);
        case (f)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return !x;
            default: return x;
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at edge %0d",
                     name, act, exp, edge_n);
        end
    endtask

    task automatic step();
        logic [3:0] sv [2];
        bit         nop;
        int         idx;
        @(posedge clk);
        edge_n++;
        if (edge_n >= MAXE) begin
            $display("FAIL edge_budget: got %0d edges, limit %0d", edge_n, MAXE);
            $fatal(1);
        end
        sv[0] = v1;
        sv[1] = v2;
        if (reset) begin
            rst_edge = edge_n;
            m_gate   = 0;
            for (int g = 0; g < 2; g++) begin
                m_f[g]    = 0;
                m_mask[g] = 0;
                m_tog[g]  = 0;
                m_full[g] = 1'b0;
                m_op[g]   = 1'b0;
            end
        end else begin
            idx = edge_n - D + 1;
            for (int g = 0; g < 2; g++) begin
                hist[g][edge_n] = faulted(m_f[g], ideal(m_gate, sv[g]));
                nop = (idx > rst_edge) ? hist[g][idx] : 1'b0;
                if (cov_clear) begin
                    m_full[g] = 1'b0;
                    m_mask[g] = 0;
                    m_tog[g]  = 0;
                end else begin
                    m_full[g] = (m_mask[g] == 32'hFFFF);
                    m_mask[g] = m_mask[g] | (1 << sv[g]);
                    if (nop != m_op[g] && m_tog[g] < 255) m_tog[g]++;
                end
                m_op[g] = nop;
            end
            if (cfg_load) begin
                m_gate = int'(cfg_gate);
                m_f[0] = int'(cfg_fault1);
                m_f[1] = int'(cfg_fault2);
            end
        end
        #1;
        check("op1", op1, m_op[0]);
        check("op2", op2, m_op[1]);
        check("cov_mask1", cov_mask1, m_mask[0]);
        check("cov_mask2", cov_mask2, m_mask[1]);
        check("cov_full1", cov_full1, m_full[0]);
        check("cov_full2", cov_full2, m_full[1]);
        check("toggles1", toggles1, m_tog[0]);
        check("toggles2", toggles2, m_tog[1]);
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic load(logic [2:0] g, logic [1:0] f1, logic [1:0] f2);
        cfg_gate   = g;
        cfg_fault1 = f1;
        cfg_fault2 = f2;
        cfg_load   = 1'b1;
        step();
        cfg_load   = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{3'b000, 2'b00, 2'b00, 4'b1111, 4'b1111, 1'b1, 1'b1};
        tbl[1]  = '{3'b000, 2'b00, 2'b00, 4'b0111, 4'b1111, 1'b0, 1'b1};
        tbl[2]  = '{3'b001, 2'b00, 2'b00, 4'b1111, 4'b0000, 1'b0, 1'b1};
        tbl[3]  = '{3'b010, 2'b00, 2'b00, 4'b0000, 4'b0100, 1'b0, 1'b1};
        tbl[4]  = '{3'b011, 2'b00, 2'b00, 4'b0000, 4'b1000, 1'b1, 1'b0};
        tbl[5]  = '{3'b100, 2'b00, 2'b00, 4'b0001, 4'b0011, 1'b1, 1'b0};
        tbl[6]  = '{3'b101, 2'b00, 2'b00, 4'b0001, 4'b0011, 1'b0, 1'b1};
        tbl[7]  = '{3'b000, 2'b01, 2'b00, 4'b1111, 4'b1111, 1'b0, 1'b1};
        tbl[8]  = '{3'b010, 2'b10, 2'b01, 4'b0000, 4'b1111, 1'b1, 1'b0};
        tbl[9]  = '{3'b100, 2'b00, 2'b11, 4'b0001, 4'b0001, 1'b1, 1'b0};
        tbl[10] = '{3'b110, 2'b00, 2'b00, 4'b1111, 4'b1110, 1'b1, 1'b0};
        tbl[11] = '{3'b111, 2'b11, 2'b00, 4'b1111, 4'b1111, 1'b0, 1'b1};

        reset = 1'b1;
        run(2);
        check("reset_op1", op1, 0);
        check("reset_mask1", cov_mask1, 0);
        check("reset_tog2", toggles2, 0);
        reset = 1'b0;

        // Exact latency on rise and fall.
        run(D);
        v1 = 4'hF;
        v2 = 4'hF;
        for (int i = 1; i <= D; i++) begin
            step();
            check("lat_rise_op1", op1, i == D);
            check("lat_rise_op2", op2, i == D);
        end
        v1 = 4'h0;
        v2 = 4'h0;
        for (int i = 1; i <= D; i++) begin
            step();
            check("lat_fall_op1", op1, i != D);
            check("lat_fall_op2", op2, i != D);
        end

        foreach (tbl[i]) begin
            v1 = tbl[i].v1;
            v2 = tbl[i].v2;
            load(tbl[i].gate, tbl[i].f1, tbl[i].f2);
            run(D);
            check($sformatf("tbl%0d_op1", i), op1, tbl[i].e1);
            check($sformatf("tbl%0d_op2", i), op2, tbl[i].e2);
        end

        // NAND sweep with coverage and toggle accounting.
        v1 = 4'h0;
        v2 = 4'h0;
        load(3'b001, 2'b00, 2'b00);
        run(D + 1);
        cov_clear = 1'b1;
        step();
        cov_clear = 1'b0;
        check("clr_mask1", cov_mask1, 0);
        for (int v = 0; v < 16; v++) begin
            v1 = v[3:0];
            v2 = v[3:0];
            for (int j = 0; j < 8; j++) begin
                step();
                if (v == 15 && j == 0) begin
                    check("sweep_mask1", cov_mask1, 16'hFFFF);
                    check("sweep_full_lag", cov_full1, 0);
                end
                if (v == 15 && j == 1) check("sweep_full1", cov_full1, 1);
            end
            check("nand_op1", op1, v != 15);
        end
        v1 = 4'h0;
        v2 = 4'h0;
        run(D);
        check("nand_toggles1", toggles1, 2);
        check("nand_full2", cov_full2, 1);

        // Stuck-at-0 on gate 1 only.
        load(3'b000, 2'b01, 2'b00);
        for (int v = 0; v < 16; v++) begin
            v1 = v[3:0];
            v2 = v[3:0];
            run(D + 1);
            check("sa0_op1", op1, 0);
            check("and_op2", op2, v == 15);
        end

        // Inverted XOR on gate 2, then config change with data in flight.
        v1 = 4'b0001;
        v2 = 4'b0001;
        load(3'b100, 2'b00, 2'b11);
        run(D);
        check("xor_op1", op1, 1);
        check("xor_inv_op2", op2, 0);
        load(3'b100, 2'b01, 2'b00);
        for (int i = 1; i < D; i++) begin
            step();
            check("inflight_op1", op1, 1);
            check("inflight_op2", op2, 0);
        end
        step();
        check("newcfg_op1", op1, 0);
        check("newcfg_op2", op2, 1);

        // Toggle saturation, then clear coinciding with a toggle.
        load(3'b000, 2'b00, 2'b00);
        for (int i = 0; i < 300; i++) begin
            v1 = (i % 2 == 1) ? 4'hF : 4'h0;
            v2 = v1;
            step();
        end
        check("sat_tog1", toggles1, 255);
        check("sat_tog2", toggles2, 255);
        v1 = 4'h0;
        v2 = 4'h0;
        cov_clear = 1'b1;
        step();
        cov_clear = 1'b0;
        check("clr_tog1", toggles1, 0);
        check("clr_vec_mask1", cov_mask1, 0);
        v1 = 4'hF;
        v2 = 4'hF;
        step();
        check("post_clr_tog1", toggles1, 1);
        check("post_clr_mask1", cov_mask1, 16'h8000);

        // Reset mid-sweep restores AND with no fault.
        v1 = 4'b0011;
        v2 = 4'b0011;
        load(3'b010, 2'b10, 2'b00);
        run(D);
        check("pre_rst_op1", op1, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_op1", op1, 0);
        check("rst_mask1", cov_mask1, 0);
        check("rst_full1", cov_full1, 0);
        check("rst_tog1", toggles1, 0);
        v1 = 4'b0001;
        run(D);
        check("rst_gate_op1", op1, 0);
        v1 = 4'hF;
        run(D);
        check("rst_fault_op1", op1, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            v1         = 4'($urandom_range(0, 15));
            v2         = 4'($urandom_range(0, 15));
            cfg_load   = ($urandom_range(0, 7) == 0);
            cfg_gate   = 3'($urandom_range(0, 7));
            cfg_fault1 = 2'($urandom_range(0, 3));
            cfg_fault2 = 2'($urandom_range(0, 3));
            cov_clear  = ($urandom_range(0, 63) == 0);
            reset      = ($urandom_range(0, 199) == 0);
            step();
        end
        reset     = 1'b0;
        cfg_load  = 1'b0;
        cov_clear = 1'b0;
        run(D);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
